fp_decode_seq: RTL

- Sequential inverse of the team's 13-bit two's-complement to float converter.
- Takes a float word (S, E[2:0], F[4:0]) and rebuilds the 13-bit two's-complement value D = (-1)^S × F × 2^E.
- Uses one left-shift per cycle under a valid/ready handshake on both sides.
- Sits downstream of the converter in the round-trip test path and feeds the board display/compare logic.

---
 rtl/fp_pkg.sv | 17 +
 rtl/cond_negate.sv | 14 +
 rtl/fp_decode_seq.sv | 84 ++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Widths, state encoding and limits shared by the float converter and its decoder.
package fp_pkg;

    localparam int DW = 13;
    localparam int EW = 3;
    localparam int FW = 5;

    // Largest decodable magnitude: 31 * 2^7.
    localparam int FP_MAX_MAG = 3968;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/cond_negate.sv
// Conditional DW-bit two's-complement negation: y = neg ? -a : a.
module cond_negate
    import fp_pkg::*;
#(
    parameter int DW = fp_pkg::DW
) (
    input  logic                 neg,
    input  logic signed [DW-1:0] a,
    output logic signed [DW-1:0] y
);

    assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/fp_decode_seq.sv
// Sequential float-to-two's-complement decoder: D = (-1)^S * F * 2^E, one left shift per clock.
module fp_decode_seq
    import fp_pkg::*;
#(
    parameter int DW = fp_pkg::DW,
    parameter int EW = fp_pkg::EW,
    parameter int FW = fp_pkg::FW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 S,
    input  logic [EW-1:0]        E,
    input  logic [FW-1:0]        F,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] D,
    output logic                 noncanon
);

    state_e                state;
    logic signed [DW-1:0]  acc;
    logic [EW-1:0]         cnt;
    logic                  sgn;
    logic                  nc;
    logic signed [DW-1:0]  acc_signed;

    // Depends on registered state only, so no accept can happen in the DONE->IDLE cycle.
    assign in_ready = (state == IDLE);

    cond_negate #(
        .DW(DW)
    ) u_cond_negate (
        .neg(sgn),
        .a  (acc),
        .y  (acc_signed)
    );

    // acc never overflows because DW >= FW + 2^EW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
            nc        <= 1'b0;
            D         <= '0;
            noncanon  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sgn   <= S;
                        cnt   <= E;
                        acc   <= {{(DW-FW){1'b0}}, F};
                        nc    <= (E != '0) && !F[FW-1];
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        acc <= acc <<< 1;
                        cnt <= cnt - 1'b1;
                    end else begin
                        D         <= acc_signed;
                        noncanon  <= nc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
